// File: rtl/logo_ram_writer_if.sv
// rtl/logo_ram_writer_if.sv - logo ROM read port and logo RAM write port bundle
interface logo_ram_writer_if #(
    parameter int ROWS  = 16,
    parameter int WIDTH = 96
);
    localparam int AW = $clog2(ROWS);

    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output ram_we,
        output ram_waddr,
        output ram_wdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  ram_we,
        input  ram_waddr,
        input  ram_wdata
    );
endinterface

// File: rtl/logo_ram_writer.sv
// rtl/logo_ram_writer.sv - per-vblank logo ROM to logo RAM copier (optional column scroll: LOGO_SCROLL_EN)
module logo_ram_writer #(
    parameter int ROWS        = 16,
    parameter int WIDTH       = 96,
    parameter int SCROLL_STEP = 1,
    localparam int AW         = $clog2(ROWS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  VGA_VS,
    input  logic                  enable,
    logo_ram_writer_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frame_cnt
);

    typedef enum logic [1:0] {IDLE, COPY, LAST} state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(ROWS - 1);
    localparam logic [AW-1:0] ADDR_PREV = AW'(ROWS - 2);

    state_t        state;
    logic          vs_q;
    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic          start;
    logic          last_write;

    // Falling vsync edge starts a copy only from IDLE; anything else is dropped.
    assign start      = vs_q & ~VGA_VS & enable & (state == IDLE);
    assign last_write = valid_q & (addr_q == ADDR_LAST);

    assign bus.ram_we    = valid_q;
    assign bus.ram_waddr = addr_q;

`ifdef LOGO_SCROLL_EN
    logic [6:0]         offset;
    logic [2*WIDTH-1:0] rot_wide;
    logic [7:0]         offset_sum;

    // Rotate left by offset: the upper half of the shifted doubled word wraps naturally.
    always_comb begin
        rot_wide      = {bus.rom_data, bus.rom_data} << offset;
        offset_sum    = {1'b0, offset} + 8'(SCROLL_STEP);
        bus.ram_wdata = valid_q ? rot_wide[2*WIDTH-1:WIDTH] : '0;
    end

    // Offset advances once per completed copy so the reader never sees it change mid-bitmap.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            offset <= '0;
        end else if (last_write) begin
            offset <= (offset_sum >= 8'(WIDTH)) ? 7'(offset_sum - 8'(WIDTH)) : offset_sum[6:0];
        end
    end
`else
    // Straight copy of the ROM row one cycle after its address was presented.
    always_comb begin
        bus.ram_wdata = valid_q ? bus.rom_data : '0;
    end
`endif

    // Copy sequencer and write pipeline; all outputs registered.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            vs_q         <= 1'b1;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            bus.rom_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            vs_q    <= VGA_VS;
            valid_q <= (state != IDLE);
            addr_q  <= bus.rom_addr;
            busy    <= (state != IDLE) | start;
            done    <= last_write;
            if (last_write) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    bus.rom_addr <= '0;
                    if (start) begin
                        state <= COPY;
                    end
                end
                COPY: begin
                    bus.rom_addr <= bus.rom_addr + 1'b1;
                    if (bus.rom_addr == ADDR_PREV) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    bus.rom_addr <= '0;
                    state        <= IDLE;
                end
                default: begin
                    bus.rom_addr <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logo_ram_writer.sv
// tb/tb_logo_ram_writer.sv - directed self-checking bench for logo_ram_writer
module tb_logo_ram_writer;

    localparam int ROWS  = 16;
    localparam int WIDTH = 96;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    logic [WIDTH-1:0] rom [ROWS];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_frame = 0;
    int exp_off   = 0;

    logo_ram_writer_if #(.ROWS(ROWS), .WIDTH(WIDTH)) bus ();

    logo_ram_writer #(.ROWS(ROWS), .WIDTH(WIDTH), .SCROLL_STEP(1)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .VGA_VS    (vs),
        .enable    (en),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model, one cycle read latency.
    always_ff @(posedge clk) begin
        bus.rom_data <= rom[bus.rom_addr];
    end

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input int off);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[(i - off + WIDTH) % WIDTH];
        end
        return r;
    endfunction

    function automatic void bump_frame();
        exp_frame = (exp_frame + 1) % 256;
`ifdef LOGO_SCROLL_EN
        exp_off = (exp_off + 1) % WIDTH;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        vs    = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.ram_we, busy, done} !== 3'b000) begin
            $display("FAIL reset_ctrl: we/busy/done=%b expected 000", {bus.ram_we, busy, done});
        end else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd0 || bus.rom_addr !== 4'd0 || bus.ram_waddr !== 4'd0) begin
            $display("FAIL reset_regs: frame_cnt=%0d rom_addr=%0d waddr=%0d expected 0/0/0",
                     frame_cnt, bus.rom_addr, bus.ram_waddr);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ram_wdata !== '0) begin
            $display("FAIL reset_wdata: got %h expected 0", bus.ram_wdata);
        end else pass_cnt++;
        rst_n     = 1'b1;
        exp_frame = 0;
        exp_off   = 0;
        repeat (2) @(negedge clk);
    endtask

    // Full cycle-by-cycle check of one copy started from IDLE with VGA_VS high.
    task automatic test_copy();
        vs = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                total_cnt++;
                if (bus.rom_addr !== 4'(k - 1)) begin
                    $display("FAIL copy_rom_addr C%0d: got %0d expected %0d", k, bus.rom_addr, k - 1);
                end else pass_cnt++;
            end
            total_cnt++;
            if (bus.ram_we !== ((k >= 2 && k <= 17) ? 1'b1 : 1'b0)) begin
                $display("FAIL copy_we C%0d: got %b", k, bus.ram_we);
            end else pass_cnt++;
            if (k >= 2 && k <= 17) begin
                total_cnt++;
                if (bus.ram_waddr !== 4'(k - 2) || bus.ram_wdata !== rotl(rom[k - 2], exp_off)) begin
                    $display("FAIL copy_write C%0d: addr=%0d data=%h expected addr=%0d data=%h",
                             k, bus.ram_waddr, bus.ram_wdata, k - 2, rotl(rom[k - 2], exp_off));
                end else pass_cnt++;
            end
            total_cnt++;
            if (busy !== ((k <= 17) ? 1'b1 : 1'b0) || done !== ((k == 18) ? 1'b1 : 1'b0)) begin
                $display("FAIL copy_busy_done C%0d: busy=%b done=%b", k, busy, done);
            end else pass_cnt++;
        end
        bump_frame();
        total_cnt++;
        if (frame_cnt !== 8'(exp_frame)) begin
            $display("FAIL copy_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
        end else pass_cnt++;
        vs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_disabled();
        int bad = 0;
        en = 1'b0;
        @(negedge clk);
        vs = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.ram_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL disabled_activity: %0d active cycles expected 0", bad);
        end else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'(exp_frame)) begin
            $display("FAIL disabled_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
        end else pass_cnt++;
        vs = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // Extra edge at C5 and enable drop mid-copy; VGA_VS then held low.
    task automatic test_retrigger();
        int nw  = 0;
        int bad = 0;
        vs = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) begin
                if (bus.ram_waddr !== 4'(nw)) bad++;
                nw++;
            end
            if (k == 3) vs = 1'b1;
            if (k == 4) en = 1'b0;
            if (k == 5) vs = 1'b0;
            if (k == 20) en = 1'b1;
        end
        bump_frame();
        total_cnt++;
        if (nw != 16 || bad != 0) begin
            $display("FAIL retrigger_writes: got %0d writes (%0d out of order) expected 16", nw, bad);
        end else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || frame_cnt !== 8'(exp_frame)) begin
            $display("FAIL retrigger_after: busy=%b frame_cnt=%0d expected 0/%0d", busy, frame_cnt, exp_frame);
        end else pass_cnt++;
        vs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_copy();
        vs = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.ram_we !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
            $display("FAIL reset_abort: we=%b busy=%b frame_cnt=%0d expected 0/0/0",
                     bus.ram_we, busy, frame_cnt);
        end else pass_cnt++;
        vs        = 1'b1;
        rst_n     = 1'b1;
        exp_frame = 0;
        exp_off   = 0;
        repeat (2) @(negedge clk);
        test_copy();
    endtask

    // Start a copy, wait for done with a bound, and capture the row-0 write.
    task automatic fast_frame(output logic [WIDTH-1:0] row0, output bit ok);
        ok   = 1'b0;
        row0 = 'x;
        vs   = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1 && bus.ram_waddr === 4'd0) row0 = bus.ram_wdata;
            if (done === 1'b1) ok = 1'b1;
        end
        if (ok) bump_frame();
        vs = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_wrap();
        logic [WIDTH-1:0] r0;
        bit ok;
        int timeouts = 0;
        test_reset();
        for (int f = 1; f <= 256; f++) begin
            fast_frame(r0, ok);
            if (!ok) timeouts++;
            if (f == 255) begin
                total_cnt++;
                if (frame_cnt !== 8'd255) begin
                    $display("FAIL wrap_255: got %0d expected 255", frame_cnt);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if (frame_cnt !== 8'd0 || timeouts != 0) begin
            $display("FAIL wrap_0: frame_cnt=%0d timeouts=%0d expected 0/0", frame_cnt, timeouts);
        end else pass_cnt++;
    endtask

`ifdef LOGO_SCROLL_EN
    task automatic test_scroll();
        logic [WIDTH-1:0] r0;
        logic [WIDTH-1:0] one;
        bit ok;
        int timeouts = 0;
        one    = '0;
        one[0] = 1'b1;
        rom[0] = one;
        test_reset();
        fast_frame(r0, ok);
        total_cnt++;
        if (!ok || r0 !== one) begin
            $display("FAIL scroll_f1: got %h ok=%0d expected %h", r0, ok, one);
        end else pass_cnt++;
        fast_frame(r0, ok);
        total_cnt++;
        if (!ok || r0 !== (one << 1)) begin
            $display("FAIL scroll_f2: got %h ok=%0d expected %h", r0, ok, one << 1);
        end else pass_cnt++;
        for (int f = 3; f <= 96; f++) begin
            fast_frame(r0, ok);
            if (!ok) timeouts++;
        end
        total_cnt++;
        if (r0 !== (one << 95) || timeouts != 0) begin
            $display("FAIL scroll_f96: got %h timeouts=%0d expected %h", r0, timeouts, one << 95);
        end else pass_cnt++;
        fast_frame(r0, ok);
        total_cnt++;
        if (!ok || r0 !== one) begin
            $display("FAIL scroll_f97: got %h ok=%0d expected %h", r0, ok, one);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            logic [3:0] nib;
            nib    = 4'(r);
            rom[r] = {24{nib}};
        end
        rom[0] = {12{8'h5A}};
        test_reset();
        test_copy();
        test_copy();
        test_disabled();
        test_retrigger();
        test_copy();
        test_reset_mid_copy();
        test_frame_wrap();
`ifdef LOGO_SCROLL_EN
        test_scroll();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
